// File: rtl/pi_request_queue_pkg.sv
// Shared definitions for the Pi register port: register addresses and bus request layout.
package pi_request_queue_pkg;

    localparam logic [2:0] PI_REG_DATA_LO = 3'd0;
    localparam logic [2:0] PI_REG_DATA_HI = 3'd1;
    localparam logic [2:0] PI_REG_ADDR_LO = 3'd2;
    localparam logic [2:0] PI_REG_ADDR_HI = 3'd3;
    localparam logic [2:0] PI_REG_CONTROL = 3'd4;

    // Request word, MSB first: fc, read, size, addr, data.
    typedef struct packed {
        logic [2:0]  fc;
        logic        read;
        logic [1:0]  size;
        logic [23:0] addr;
        logic [31:0] data;
    } req_t;

    localparam int unsigned REQ_WIDTH    = $bits(req_t);
    localparam int unsigned REQ_DATA_LSB = 0;
    localparam int unsigned REQ_ADDR_LSB = 32;
    localparam int unsigned REQ_SIZE_LSB = 56;
    localparam int unsigned REQ_READ_BIT = 58;
    localparam int unsigned REQ_FC_LSB   = 59;

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO with full/empty flags and an occupancy count.
module req_fifo #(
    parameter int unsigned WIDTH = 62,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             rd_ok, wr_ok;

    // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + 1'b1;
            end else if (!wr_ok && rd_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == (PW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/pi_request_queue.sv
// Pi register port front end: strobe sync, register decode, request queue and
// response/status tracking for the 68000 bus FSM.
module pi_request_queue
    import pi_request_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        PI_WR,
    input  logic [2:0]  PI_A,
    input  logic [15:0] PI_DIN,
    output logic        REQ_VALID,
    input  logic        REQ_READY,
    output logic [23:0] REQ_ADDR,
    output logic [31:0] REQ_DATA,
    output logic [1:0]  REQ_SIZE,
    output logic        REQ_READ,
    output logic [2:0]  REQ_FC,
    input  logic        RSP_DONE,
    input  logic        RSP_OK,
    input  logic [31:0] RSP_DATA,
    output logic [31:0] RD_DATA,
    output logic        BUSY,
    output logic        TERM_OK,
    output logic        OVERFLOW,
    output logic [14:0] CONTROL
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                 wr_meta_q, wr_sync_q, wr_prev_q, detect;
    logic [31:0]          stage_data_q, stage_data_d;
    logic [15:0]          stage_addr_q, stage_addr_d;
    logic [14:0]          control_q, control_d;
    logic                 overflow_q, overflow_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_read_q, inflight_read_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 term_ok_q, term_ok_d;
    logic                 busy_q, busy_d;
    req_t                 push_req;
    logic [REQ_WIDTH-1:0] head;
    logic                 push, pop, fifo_wr, full, empty;
    logic [CW-1:0]        count, count_next;

    // Synchroniser idles high so reset cannot fake a falling edge.
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            wr_meta_q <= 1'b1;
            wr_sync_q <= 1'b1;
            wr_prev_q <= 1'b1;
        end else begin
            wr_meta_q <= PI_WR;
            wr_sync_q <= wr_meta_q;
            wr_prev_q <= wr_sync_q;
        end
    end

    assign detect = ~wr_sync_q & wr_prev_q;
    assign push   = detect & (PI_A == PI_REG_ADDR_HI);
    assign pop    = ~empty & REQ_READY;
    assign fifo_wr = push & (~full | pop);

    assign push_req = '{
        fc:   PI_DIN[13:11],
        read: PI_DIN[10],
        size: PI_DIN[9:8],
        addr: {PI_DIN[7:0], stage_addr_q},
        data: stage_data_q
    };

    always_comb begin
        stage_data_d = stage_data_q;
        stage_addr_d = stage_addr_q;
        control_d    = control_q;
        overflow_d   = overflow_q;
        if (detect) begin
            case (PI_A)
                PI_REG_DATA_LO: stage_data_d[15:0]  = PI_DIN;
                PI_REG_DATA_HI: stage_data_d[31:16] = PI_DIN;
                PI_REG_ADDR_LO: stage_addr_d        = PI_DIN;
                PI_REG_CONTROL: begin
                    if (PI_DIN[15]) begin
                        control_d = control_q | PI_DIN[14:0];
                    end else begin
                        control_d  = control_q & ~PI_DIN[14:0];
                        overflow_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (push && !fifo_wr) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        inflight_d      = inflight_q;
        inflight_read_d = inflight_read_q;
        rd_data_d       = rd_data_q;
        term_ok_d       = term_ok_q;
        if (RSP_DONE && inflight_q) begin
            term_ok_d  = RSP_OK;
            inflight_d = 1'b0;
            if (inflight_read_q) begin
                rd_data_d = RSP_DATA;
            end
        end
        // A pop in the completion cycle starts the next transfer, so it wins.
        if (pop) begin
            inflight_d      = 1'b1;
            inflight_read_d = head[REQ_READ_BIT];
        end
        count_next = count;
        if (fifo_wr && !pop) begin
            count_next = count + 1'b1;
        end else if (!fifo_wr && pop) begin
            count_next = count - 1'b1;
        end
        busy_d = (count_next != '0) | inflight_d;
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            stage_data_q    <= '0;
            stage_addr_q    <= '0;
            control_q       <= '0;
            overflow_q      <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_read_q <= 1'b0;
            rd_data_q       <= '0;
            term_ok_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            stage_data_q    <= stage_data_d;
            stage_addr_q    <= stage_addr_d;
            control_q       <= control_d;
            overflow_q      <= overflow_d;
            inflight_q      <= inflight_d;
            inflight_read_q <= inflight_read_d;
            rd_data_q       <= rd_data_d;
            term_ok_q       <= term_ok_d;
            busy_q          <= busy_d;
        end
    end

    req_fifo #(
        .WIDTH(REQ_WIDTH),
        .DEPTH(DEPTH)
    ) u_req_fifo (
        .sys_clk (SYSCLK),
        .rst     (RESET),
        .wr_en   (fifo_wr),
        .wr_data (push_req),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign REQ_VALID = ~empty;
    assign REQ_ADDR  = head[REQ_ADDR_LSB +: 24];
    assign REQ_DATA  = head[REQ_DATA_LSB +: 32];
    assign REQ_SIZE  = head[REQ_SIZE_LSB +: 2];
    assign REQ_READ  = head[REQ_READ_BIT];
    assign REQ_FC    = head[REQ_FC_LSB +: 3];
    assign RD_DATA   = rd_data_q;
    assign BUSY      = busy_q;
    assign TERM_OK   = term_ok_q;
    assign OVERFLOW  = overflow_q;
    assign CONTROL   = control_q;

endmodule

// File: tb/tb_pi_request_queue.sv
// Bench for pi_request_queue: directed scenarios plus random traffic against a queue model.
module tb_pi_request_queue;
    localparam int unsigned DEPTH = 4;

    logic        sys_clk, rst, pi_wr;
    logic [2:0]  pi_a;
    logic [15:0] pi_din;
    logic        req_valid, req_ready, req_read;
    logic [23:0] req_addr;
    logic [31:0] req_data, rsp_data, rd_data;
    logic [1:0]  req_size;
    logic [2:0]  req_fc;
    logic        rsp_done, rsp_ok, busy, term_ok, overflow;
    logic [14:0] control;

    int vectors = 0;
    int errors  = 0;

    pi_request_queue #(.DEPTH(DEPTH)) dut (
        .SYSCLK    (sys_clk),
        .RESET     (rst),
        .PI_WR     (pi_wr),
        .PI_A      (pi_a),
        .PI_DIN    (pi_din),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_ADDR  (req_addr),
        .REQ_DATA  (req_data),
        .REQ_SIZE  (req_size),
        .REQ_READ  (req_read),
        .REQ_FC    (req_fc),
        .RSP_DONE  (rsp_done),
        .RSP_OK    (rsp_ok),
        .RSP_DATA  (rsp_data),
        .RD_DATA   (rd_data),
        .BUSY      (busy),
        .TERM_OK   (term_ok),
        .OVERFLOW  (overflow),
        .CONTROL   (control)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request queue plus response/status state.
    logic [61:0] mq[$];
    logic [61:0] m_head, m_new, m_popped;
    logic [31:0] m_stage_data, m_rd_data;
    logic [15:0] m_stage_addr;
    logic [14:0] m_control;
    logic        m_inflight, m_inf_read, m_term_ok, m_overflow, m_busy;
    logic        m_last_wr, m_pop, m_wr;
    int          m_pend;

    initial begin
        forever begin
            @(posedge sys_clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_stage_data = '0; m_stage_addr = '0; m_control = '0;
                m_inflight = 0; m_inf_read = 0; m_term_ok = 0; m_overflow = 0;
                m_rd_data = '0; m_busy = 0; m_last_wr = 1; m_pend = 0;
            end else begin
                m_pop = (mq.size() != 0) && req_ready;
                m_wr  = 0;
                // A write takes effect on the third clock edge after PI_WR is seen low.
                if (m_pend > 0) begin
                    m_pend--;
                    if (m_pend == 0) m_wr = 1;
                end
                if (!pi_wr && m_last_wr) m_pend = 2;
                m_last_wr = pi_wr;
                if (rsp_done && m_inflight) begin
                    m_term_ok = rsp_ok;
                    if (m_inf_read) m_rd_data = rsp_data;
                    m_inflight = 0;
                end
                if (m_pop) begin
                    m_popped   = mq.pop_front();
                    m_inflight = 1;
                    m_inf_read = m_popped[58];
                end
                if (m_wr) begin
                    case (pi_a)
                        3'd0: m_stage_data[15:0]  = pi_din;
                        3'd1: m_stage_data[31:16] = pi_din;
                        3'd2: m_stage_addr        = pi_din;
                        3'd3: begin
                            m_new = {pi_din[13:8], pi_din[7:0], m_stage_addr, m_stage_data};
                            if (mq.size() < DEPTH) mq.push_back(m_new);
                            else m_overflow = 1;
                        end
                        3'd4: begin
                            if (pi_din[15]) m_control = m_control | pi_din[14:0];
                            else begin
                                m_control  = m_control & ~pi_din[14:0];
                                m_overflow = 0;
                            end
                        end
                        default: ;
                    endcase
                end
                m_busy = (mq.size() != 0) || m_inflight;
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            check("req_valid", req_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                m_head = mq[0];
                check("req_fc",   req_fc,   m_head[61:59]);
                check("req_read", req_read, m_head[58]);
                check("req_size", req_size, m_head[57:56]);
                check("req_addr", req_addr, m_head[55:32]);
                check("req_data", req_data, m_head[31:0]);
            end
            check("busy",     busy,     m_busy);
            check("rd_data",  rd_data,  m_rd_data);
            check("term_ok",  term_ok,  m_term_ok);
            check("overflow", overflow, m_overflow);
            check("control",  control,  m_control);
        end
    end

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pi_write(input logic [2:0] a, input logic [15:0] d, input logic rdy);
        pi_a = a; pi_din = d; pi_wr = 1'b0; req_ready = 1'b0; rsp_done = 1'b0;
        tick; tick;
        req_ready = rdy;
        tick;
        req_ready = 1'b0;
        tick; tick;
        pi_wr = 1'b1;
        tick; tick; tick;
    endtask

    task automatic complete(input logic ok, input logic [31:0] d);
        rsp_done = 1'b1; rsp_ok = ok; rsp_data = d;
        tick;
        rsp_done = 1'b0;
    endtask

    logic [7:0] drained[$];

    task automatic drain;
        drained.delete();
        req_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && req_valid; k++) begin
            drained.push_back(req_addr[23:16]);
            tick;
        end
        req_ready = 1'b0;
        check("drain_bound", req_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    int r, n;

    initial begin
        rst = 1'b1; pi_wr = 1'b1; pi_a = '0; pi_din = '0;
        req_ready = 1'b0; rsp_done = 1'b0; rsp_ok = 1'b0; rsp_data = '0;
        tick; tick;
        rst = 1'b0;
        tick;
        check("rst_valid",    req_valid, 1'b0);
        check("rst_addr",     req_addr,  24'h0);
        check("rst_busy",     busy,      1'b0);
        check("rst_overflow", overflow,  1'b0);

        pi_write(3'd0, 16'h1234, 1'b0);
        pi_write(3'd1, 16'hABCD, 1'b0);
        pi_write(3'd2, 16'h0400, 1'b0);
        pi_write(3'd3, 16'h0DFC, 1'b0);
        check("t1_valid", req_valid, 1'b1);
        check("t1_addr",  req_addr,  24'hFC0400);
        check("t1_data",  req_data,  32'hABCD1234);
        check("t1_fc",    req_fc,    3'd1);
        check("t1_read",  req_read,  1'b1);
        check("t1_size",  req_size,  2'd1);
        check("t1_busy",  busy,      1'b1);

        req_ready = 1'b1;
        tick;
        req_ready = 1'b0;
        check("t2_popped", req_valid, 1'b0);
        check("t2_busy",   busy,      1'b1);
        complete(1'b1, 32'hDEADBEEF);
        check("t2_rd_data", rd_data, 32'hDEADBEEF);
        check("t2_term_ok", term_ok, 1'b1);
        check("t2_busy_lo", busy,    1'b0);

        for (int i = 0; i <= DEPTH; i++) pi_write(3'd3, 16'h0410 + 16'(i), 1'b0);
        check("t3_overflow", overflow, 1'b1);
        drain();
        check("t3_count", drained.size(), DEPTH);
        for (int i = 0; i < drained.size(); i++) check("t3_order", drained[i], 8'h10 + 8'(i));
        complete(1'b1, 32'h0);
        pi_write(3'd4, 16'h0000, 1'b0);
        check("t3_ovf_clear", overflow, 1'b0);

        for (int i = 0; i < DEPTH; i++) pi_write(3'd3, 16'h0430 + 16'(i), 1'b0);
        pi_write(3'd3, 16'h0440, 1'b1);
        check("t4_no_overflow", overflow, 1'b0);
        drain();
        check("t4_count", drained.size(), DEPTH);
        if (drained.size() == DEPTH) begin
            check("t4_first", drained[0], 8'h31);
            check("t4_last",  drained[DEPTH-1], 8'h40);
        end
        complete(1'b0, 32'h0);

        pi_write(3'd4, 16'h8005, 1'b0);
        check("t5_set", control, 15'h0005);
        pi_write(3'd4, 16'h0001, 1'b0);
        check("t5_clr", control, 15'h0004);

        for (int i = 0; i < 3; i++) pi_write(3'd3, 16'h0450 + 16'(i), 1'b0);
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_valid",   req_valid, 1'b0);
        check("t6_addr",    req_addr,  24'h0);
        check("t6_data",    req_data,  32'h0);
        check("t6_fc",      req_fc,    3'd0);
        check("t6_busy",    busy,      1'b0);
        check("t6_rd_data", rd_data,   32'h0);
        check("t6_control", control,   15'h0);
        tick;
        rst = 1'b0;
        tick;
        complete(1'b1, 32'h12345678);
        check("t6_late_done", rd_data, 32'h0);
        check("t6_late_ok",   term_ok, 1'b0);

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 19);
            if (r < 7) begin
                pi_write(3'd3, 16'($urandom), 1'($urandom_range(0, 1)));
            end else if (r < 11) begin
                pi_write(3'($urandom_range(0, 7)), 16'($urandom), 1'b0);
            end else if (r == 19 && $urandom_range(0, 3) == 0) begin
                rst = 1'b1;
                tick;
                rst = 1'b0;
                tick;
            end else begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    req_ready = 1'($urandom_range(0, 1));
                    rsp_done  = ($urandom_range(0, 2) == 0);
                    rsp_ok    = 1'($urandom_range(0, 1));
                    rsp_data  = $urandom;
                    tick;
                end
                req_ready = 1'b0;
                rsp_done  = 1'b0;
            end
        end
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pi_request_queue.md
# pi_request_queue

Sits between the Raspberry Pi GPIO register port and the 68000 bus-cycle state machine. Synchronises the Pi write strobe into the system clock domain and decodes register writes. Assembles complete bus requests and queues them in a small FIFO that the bus FSM drains with a valid/ready handshake. It also captures read results and produces the busy/status bits the Pi polls.

## Interface
Parameters:
- DEPTH, 4: request FIFO entries; power of two, 2..16.

Ports:
- SYSCLK  in  1  system clock from PLL; the only clock in this block.
- RESET  in  1  asynchronous, active-high reset.
- PI_WR  in  1  Pi write strobe, active low, asynchronous.
- PI_A  in  3  Pi register address, asynchronous.
- PI_DIN  in  16  Pi write data, asynchronous.
- REQ_VALID  out  1  FIFO head holds a request.
- REQ_READY  in  1  bus FSM pops the head this cycle.
- REQ_ADDR  out  24  head address.
- REQ_DATA  out  32  head write data.
- REQ_SIZE  out  2  head size; bit1 set means a two-word transfer.
- REQ_READ  out  1  head is a read.
- REQ_FC  out  3  head function code.
- RSP_DONE  in  1  one-cycle pulse: the in-flight request has finished.
- RSP_OK  in  1  normal termination, qualified by RSP_DONE.
- RSP_DATA  in  32  read data, qualified by RSP_DONE.
- RD_DATA  out  32  last captured read data.
- BUSY  out  1  FIFO not empty, or a request is in flight.
- TERM_OK  out  1  RSP_OK value from the last completion.
- OVERFLOW  out  1  sticky flag: a request was dropped because the FIFO was full.
- CONTROL  out  15  control register.

## Operation
- PI_WR passes through a 2-FF synchroniser plus an edge register. A falling edge is detected when sync = 0 and the previous sample = 1. PI_A and PI_DIN are sampled in the detect cycle, with no separate synchronisation.
- Decode on detect:
  - DATA_LO (0): load staging data[15:0].
  - DATA_HI (1): load staging data[31:16].
  - ADDR_LO (2): load staging addr[15:0].
  - ADDR_HI (3): push {PI_DIN[13:11] fc, PI_DIN[10] read, PI_DIN[9:8] size, PI_DIN[7:0] & staging addr, staging data}.
  - CONTROL (4): if PI_DIN[15]=1, CONTROL |= PI_DIN[14:0]. Otherwise CONTROL &= ~PI_DIN[14:0] and OVERFLOW is cleared.
  - Addresses 5..7: ignored.
- Staging registers keep their contents after a push, so a repeat request needs only an ADDR_HI write.
- Push when full: the push is accepted only if REQ_READY is also high that cycle. Otherwise the entry is dropped, OVERFLOW is set, and FIFO contents are unchanged.
- Pop: REQ_VALID & REQ_READY sets the inflight flag. RSP_DONE clears inflight.
  - If RSP_DONE and a pop fall in the same cycle, inflight stays 1.
  - RSP_DONE while inflight=0 is ignored.
- On RSP_DONE & inflight: RD_DATA <= RSP_DATA when the completed request was a read (tracked in a registered copy taken at pop). TERM_OK <= RSP_OK in all cases.
- BUSY = ~empty | inflight, registered.
- Simultaneous push and pop in a non-full, non-empty FIFO: both happen and the count is unchanged.

## Timing
- Reset values: REQ_VALID 0, REQ_* payload 0, RD_DATA 0, BUSY 0, TERM_OK 0, OVERFLOW 0, CONTROL 0. Staging registers are 0, pointers 0, inflight 0.
- Reset mid-operation: queued requests are discarded and inflight is cleared. A RSP_DONE arriving after reset is ignored.
- PI_WR low to decode: 3 SYSCLK cycles. The Pi must hold PI_A and PI_DIN stable for at least 4 SYSCLK cycles after PI_WR falls.
- ADDR_HI write to REQ_VALID: REQ_VALID rises 1 cycle after the decode cycle (FIFO write, then registered head).
- Head outputs are registered. The next entry appears in the cycle after a pop.
- BUSY falls 1 cycle after the RSP_DONE that empties the queue.

## Structure
- Register address constants (0..4) and request field offsets live in the shared global header, next to the existing PI_REG_* definitions.
- The sub-module `req_fifo` is a synchronous FIFO: width 62 = 3+1+2+24+32, depth DEPTH, with full/empty flags and a count of width $clog2(DEPTH)+1.
- Everything else (synchroniser, decode, staging, inflight/response tracking, status) is in the top level.

## Test plan
- Write DATA_LO=0x1234, DATA_HI=0xABCD, ADDR_LO=0x0400, ADDR_HI=0x0DFC. Required: REQ_VALID with ADDR=0xFC0400, DATA=0xABCD1234, FC=1, READ=1, SIZE=1, and BUSY=1.
- Pop a read request, then drive RSP_DONE with RSP_DATA=0xDEADBEEF and RSP_OK=1. Required: RD_DATA=0xDEADBEEF, TERM_OK=1, BUSY=0 one cycle later.
- Push DEPTH+1 requests with REQ_READY=0. Required: OVERFLOW=1 and exactly DEPTH entries popped, in order. A CONTROL write of 0x0000 clears OVERFLOW.
- Full FIFO, with an ADDR_HI push and REQ_READY in the same cycle. Required: no overflow, and the new entry is last in order.
- CONTROL writes 0x8005, then 0x0001. Required: CONTROL=0x0005, then 0x0004.
- Assert RESET while 2 entries are queued and inflight=1. Required: all outputs at reset values; a later RSP_DONE leaves RD_DATA=0.
